// File: rtl/jacobi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jacobi_pkg
// Description : Shared constants, types and helpers for the Jacobi cluster
//               row-reduction stage.
// Revision    : 1.0 - initial release
// ============================================================================
package jacobi_pkg;

  // IEEE-754 single precision word layout
  localparam int FP_W     = 32;
  localparam int SIGN_BIT = 31;

  typedef logic [FP_W-1:0] fp_t;

  localparam fp_t FP_POS_ZERO = 32'h0000_0000;

  // Row accumulator controller states
  localparam logic [1:0] c_st_accum = 2'd0;
  localparam logic [1:0] c_st_drain = 2'd1;
  localparam logic [1:0] c_st_out   = 2'd2;

  // Apply the optional sign flip and canonicalise both zeros to +0 so the
  // adder never sees -0 and a lone -0 element reduces to +0.
  function automatic fp_t make_elem(input fp_t data, input logic neg);
    fp_t r;
    if (data[SIGN_BIT-1:0] == '0) begin
      r = FP_POS_ZERO;
    end else begin
      r = {data[SIGN_BIT] ^ neg, data[SIGN_BIT-1:0]};
    end
    return r;
  endfunction

endpackage : jacobi_pkg
`default_nettype wire

// File: rtl/issue_tracker.sv
`default_nettype none
// ============================================================================
// Module      : issue_tracker
// Description : Tracks operand pairs travelling through the external pipelined
//               adder. A LAT-deep tag shift register flags the cycle in which
//               each result returns; a counter holds the number in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module issue_tracker #(
  parameter int LAT   = 6,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue,
  output logic             ret_v,
  output logic [CNT_W-1:0] inflight
);

  logic [LAT-1:0]   r_tags;
  logic [CNT_W-1:0] r_inflight;

  generate
    if (LAT == 1) begin : g_lat_one
      // Single-stage adder: the tag returns on the cycle after issue
      always_ff @(posedge clk) begin
        if (!rst) begin
          r_tags <= '0;
        end else begin
          r_tags <= issue;
        end
      end
    end else begin : g_lat_multi
      // Tag enters at bit 0 on issue and reaches bit LAT-1 with its result
      always_ff @(posedge clk) begin
        if (!rst) begin
          r_tags <= '0;
        end else begin
          r_tags <= {r_tags[LAT-2:0], issue};
        end
      end
    end
  endgenerate

  // In-flight count: +1 per issue, -1 per return, unchanged when both occur
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_inflight <= '0;
    end else begin
      case ({issue, ret_v})
        2'b10:   r_inflight <= r_inflight + CNT_W'(1);
        2'b01:   r_inflight <= r_inflight - CNT_W'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  assign ret_v    = r_tags[LAT-1];
  assign inflight = r_inflight;

endmodule : issue_tracker
`default_nettype wire

// File: rtl/jacobi_row_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : jacobi_row_accumulator
// Description : Reduces one row of IEEE-754 products to a single sum by
//               pairing incoming elements and returning adder results around
//               an external pipelined adder, then hands the row sum
//               downstream with a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module jacobi_row_accumulator
  import jacobi_pkg::*;
#(
  parameter int LAT   = 6,
  parameter int CNT_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_neg,
  input  logic        in_last,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  output logic        add_op,
  output logic        add_ce,
  input  logic [31:0] add_result,
  output logic        sum_valid,
  input  logic        sum_ready,
  output logic [31:0] sum_data
);

  logic [1:0]       r_state;
  fp_t              r_pend;
  logic             r_pend_v;
  logic             r_sum_valid;
  fp_t              r_sum_data;

  fp_t              w_elem;
  fp_t              w_src;
  fp_t              w_op_a;
  fp_t              w_op_b;
  fp_t              w_pend_val;
  logic             w_take_e;
  logic             w_ret_v;
  logic             w_issue;
  logic             w_issue_q;
  logic             w_pend_load;
  logic             w_pend_clr;
  logic             w_done;
  logic [CNT_W-1:0] w_inflight;

  issue_tracker #(
    .LAT   (LAT),
    .CNT_W (CNT_W)
  ) u_issue (
    .clk      (clk),
    .rst      (rst),
    .issue    (w_issue),
    .ret_v    (w_ret_v),
    .inflight (w_inflight)
  );

  assign w_elem   = make_elem(in_data, in_neg);
  assign in_ready = (r_state == c_st_accum);
  assign w_take_e = in_valid & in_ready;

  // Combine two available sources into an adder issue, or park a lone source
  always_comb begin
    w_issue     = 1'b0;
    w_op_a      = r_pend;
    w_op_b      = w_elem;
    w_src       = w_elem;
    w_pend_load = 1'b0;
    w_pend_clr  = 1'b0;
    w_pend_val  = w_elem;
    if (w_ret_v && w_take_e) begin
      // Returning result pairs with the new element; pend is untouched
      w_issue = 1'b1;
      w_op_a  = add_result;
      w_op_b  = w_elem;
    end else if (w_ret_v || w_take_e) begin
      w_src = w_ret_v ? add_result : w_elem;
      if (r_pend_v) begin
        w_issue    = 1'b1;
        w_op_a     = r_pend;
        w_op_b     = w_src;
        w_pend_clr = 1'b1;
      end else begin
        w_pend_load = 1'b1;
        w_pend_val  = w_src;
      end
    end
  end

  // Row is fully reduced once only the parked value remains
  assign w_done = (r_state == c_st_drain) && r_pend_v &&
                  (w_inflight == '0) && !w_ret_v;

  // Operands are presented in the issue cycle; idle and reset drive zeros
  assign w_issue_q = w_issue & rst;
  assign add_a     = w_issue_q ? w_op_a : FP_POS_ZERO;
  assign add_b     = w_issue_q ? w_op_b : FP_POS_ZERO;
  assign add_op    = 1'b0;
  assign add_ce    = rst;

  // Parked operand register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pend   <= FP_POS_ZERO;
      r_pend_v <= 1'b0;
    end else begin
      if (w_pend_load) begin
        r_pend   <= w_pend_val;
        r_pend_v <= 1'b1;
      end else if (w_pend_clr || w_done) begin
        r_pend_v <= 1'b0;
      end
    end
  end

  // Row controller: accept elements, drain the adder, present the sum
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= c_st_accum;
      r_sum_valid <= 1'b0;
      r_sum_data  <= FP_POS_ZERO;
    end else begin
      case (r_state)
        c_st_accum: begin
          if (w_take_e && in_last) begin
            r_state <= c_st_drain;
          end
        end
        c_st_drain: begin
          if (w_done) begin
            r_state     <= c_st_out;
            r_sum_data  <= r_pend;
            r_sum_valid <= 1'b1;
          end
        end
        c_st_out: begin
          if (sum_ready) begin
            r_state     <= c_st_accum;
            r_sum_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= c_st_accum;
          r_sum_valid <= 1'b0;
        end
      endcase
    end
  end

  assign sum_valid = r_sum_valid;
  assign sum_data  = r_sum_data;

endmodule : jacobi_row_accumulator
`default_nettype wire

// File: tb/tb_jacobi_row_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_jacobi_row_accumulator
// Description : Self-checking bench for jacobi_row_accumulator with a
//               behavioural LAT-cycle adder and an integer row-sum model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_jacobi_row_accumulator;

  localparam int LAT   = 6;
  localparam int CNT_W = 4;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_neg;
  logic        in_last;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_op;
  logic        add_ce;
  logic [31:0] add_result;
  logic        sum_valid;
  logic        sum_ready;
  logic [31:0] sum_data;

  int errors = 0;
  int checks = 0;
  int issue_total = 0;

  jacobi_row_accumulator #(.LAT(LAT), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_neg     (in_neg),
    .in_last    (in_last),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_op     (add_op),
    .add_ce     (add_ce),
    .add_result (add_result),
    .sum_valid  (sum_valid),
    .sum_ready  (sum_ready),
    .sum_data   (sum_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Integer-valued float helpers (all bench values are small integers)
  function automatic logic [31:0] int_to_fp(input int v);
    logic [31:0] m;
    int          msb;
    logic        s;
    if (v == 0) return 32'h0;
    s = (v < 0);
    m = s ? 32'(-v) : 32'(v);
    msb = 0;
    for (int i = 0; i < 24; i++) if (m[i]) msb = i;
    m = m << (23 - msb);
    return {s, 8'(127 + msb), m[22:0]};
  endfunction

  function automatic int fp_to_int(input logic [31:0] f);
    int          e;
    logic [31:0] m;
    int          mag;
    e = int'(f[30:23]);
    if (e == 0) return 0;
    m = {8'h0, 1'b1, f[22:0]};
    if (e >= 150) mag = int'(m << (e - 150));
    else          mag = int'(m >> (150 - e));
    return f[31] ? -mag : mag;
  endfunction

  // Behavioural adder: result appears LAT cycles after A/B are presented
  logic [31:0] pipe [LAT];
  always @(posedge clk) begin
    if (add_ce) begin
      pipe[0] <= int_to_fp(fp_to_int(add_a) + fp_to_int(add_b));
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign add_result = pipe[LAT-1];

  always @(posedge clk) begin
    if (rst && dut.u_issue.issue) issue_total = issue_total + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one element and hold it until accepted
  task automatic send(input logic [31:0] d, input logic n, input logic l);
    int t;
    t = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_neg = n; in_last = l;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("send_timeout", 32'(t), 32'd0);
    @(posedge clk);
    #1 in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Wait for the sum, compare it, optionally stall, then complete handshake
  task automatic get_sum(input logic [31:0] exp, input string tag, input int hold);
    int t;
    bit rdy_bad;
    bit stab_bad;
    t = 0; rdy_bad = 0; stab_bad = 0;
    while (!sum_valid && t < 500) begin
      if (in_ready) rdy_bad = 1;
      @(negedge clk);
      t++;
    end
    check({tag, "_timeout"}, 32'(t < 500), 32'd1);
    check({tag, "_data"}, sum_data, exp);
    check({tag, "_in_ready_low"}, 32'(rdy_bad | in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!sum_valid || sum_data !== exp || in_ready) stab_bad = 1;
    end
    if (hold > 0) check({tag, "_hold_stable"}, 32'(stab_bad), 32'd0);
    @(negedge clk);
    sum_ready = 1'b1;
    @(posedge clk);
    #1 sum_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(sum_valid), 32'd0);
    check({tag, "_next_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    int v;
    int sum;
    int hold;
    logic ng;
    bit saw;

    rst = 1'b0; in_valid = 1'b0; in_data = '0; in_neg = 1'b0;
    in_last = 1'b0; sum_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sum_valid", 32'(sum_valid), 32'd0);
    check("rst_sum_data", sum_data, 32'h0);
    check("rst_add_a", add_a, 32'h0);
    check("rst_add_b", add_b, 32'h0);
    check("rst_add_ce", 32'(add_ce), 32'd0);
    check("rst_add_op", 32'(add_op), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("run_add_ce", 32'(add_ce), 32'd1);
    check("run_inflight", 32'(dut.u_issue.inflight), 32'd0);

    // Row 1,2,3,4 -> 10.0
    base = issue_total;
    send(32'h3F800000, 1'b0, 1'b0);
    send(32'h40000000, 1'b0, 1'b0);
    send(32'h40400000, 1'b0, 1'b0);
    send(32'h40800000, 1'b0, 1'b1);
    get_sum(32'h41200000, "sum_1234", 0);
    check("sum_1234_issues", 32'(issue_total - base), 32'd3);
    check("sum_1234_inflight", 32'(dut.u_issue.inflight), 32'd0);
    saw = 0;
    repeat (10) begin @(negedge clk); if (sum_valid) saw = 1; end
    check("sum_1234_single_valid", 32'(saw), 32'd0);

    // Single element: sum two cycles after acceptance, no adder issue
    base = issue_total;
    send(32'h40A00000, 1'b0, 1'b1);
    @(negedge clk);
    check("single_cycle1_valid", 32'(sum_valid), 32'd0);
    @(negedge clk);
    check("single_cycle2_valid", 32'(sum_valid), 32'd1);
    get_sum(32'h40A00000, "single", 0);
    check("single_issues", 32'(issue_total - base), 32'd0);

    // Sign flip: {3.0, -(2.0)} -> 1.0
    send(32'h40400000, 1'b0, 1'b0);
    send(32'h40000000, 1'b1, 1'b1);
    get_sum(32'h3F800000, "neg_row", 0);

    // Lone -0 reduces to +0
    send(32'h80000000, 1'b0, 1'b1);
    get_sum(32'h00000000, "neg_zero", 0);

    // 17 ones with a bubble every third element -> 17.0
    base = issue_total;
    for (int i = 0; i < 17; i++) begin
      if (i % 3 == 2) @(negedge clk);
      send(32'h3F800000, 1'b0, i == 16);
    end
    get_sum(32'h41880000, "ones17", 0);
    check("ones17_issues", 32'(issue_total - base), 32'd16);

    // Downstream stall for 10 cycles on {2.0, 3.0} -> 5.0, then a new row
    send(32'h40000000, 1'b0, 1'b0);
    send(32'h40400000, 1'b0, 1'b1);
    get_sum(32'h40A00000, "stall", 10);
    send(32'h40E00000, 1'b0, 1'b1);
    get_sum(32'h40E00000, "after_stall", 0);

    // Reset mid-DRAIN with three results in flight
    for (int i = 1; i <= 6; i++) send(int_to_fp(i), 1'b0, i == 6);
    check("drain_inflight", 32'(dut.u_issue.inflight), 32'd3);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("mid_rst_sum_data", sum_data, 32'h0);
    check("mid_rst_inflight", 32'(dut.u_issue.inflight), 32'd0);
    saw = 0;
    repeat (30) begin @(negedge clk); if (sum_valid) saw = 1; end
    check("mid_rst_no_sum", 32'(saw), 32'd0);
    send(32'h3F800000, 1'b0, 1'b0);
    send(32'h3F800000, 1'b0, 1'b1);
    get_sum(32'h40000000, "post_rst", 0);

    // Randomised rows against an integer row-sum model
    for (int r = 0; r < 8; r++) begin
      n = int'($urandom_range(1, 20));
      sum = 0;
      base = issue_total;
      for (int i = 0; i < n; i++) begin
        v = int'($urandom_range(0, 40)) - 20;
        ng = 1'($urandom_range(0, 1));
        sum += ng ? -v : v;
        send(int_to_fp(v), ng, i == n - 1);
        if ($urandom_range(0, 3) == 0) @(negedge clk);
      end
      hold = int'($urandom_range(0, 3));
      get_sum(int_to_fp(sum), "rand", hold);
      check("rand_issues", 32'(issue_total - base), 32'(n - 1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_jacobi_row_accumulator
`default_nettype wire

// File: doc/jacobi_row_accumulator.md
Name: jacobi_row_accumulator

Overview:
- Streaming reduction stage sitting directly around the pipelined single-precision adder_subtractor of the Jacobi cluster.
- Accepts one row's stream of IEEE-754 products, issues operand pairs to the adder, and folds returning results back in until one sum remains.
- Presents that row sum downstream with a valid/ready handshake.
- The adder is instantiated outside this block; this block drives its A/B/op/ce and consumes its result.

Parameters:
- LAT, 6, adder_subtractor latency in clk cycles from A/B to result. Must equal the instantiated adder's latency.
- CNT_W, 4, width of in-flight counter; 2**CNT_W > LAT.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-low reset
- in_valid  in  1  input element valid
- in_ready  out  1  block can accept element
- in_data  in  32  IEEE-754 single element
- in_neg  in  1  flip sign bit of in_data before use
- in_last  in  1  final element of row; qualified by in_valid & in_ready
- add_a  out  32  adder operand A
- add_b  out  32  adder operand B
- add_op  out  1  adder op; constant 0 (add)
- add_ce  out  1  adder clock enable; 0 while rst low, else 1
- add_result  in  32  adder result, valid LAT cycles after issue
- sum_valid  out  1  row sum available
- sum_ready  in  1  downstream accepts sum
- sum_data  out  32  row sum

Behaviour:
- Reset (rst=0 at posedge):
  - state=ACCUM, pend_v=0, inflight=0, issue shift register cleared.
  - sum_valid=0, sum_data=0, add_a=add_b=0.
  - Results already in the adder pipeline are discarded because their shift-register tags are cleared.
- Issue tracking:
  - LAT-bit shift register; bit 0 is set on the cycle a pair is issued.
  - ret_v = bit LAT-1 marks add_result valid.
  - inflight increments on issue, decrements on ret_v; both in the same cycle leaves it unchanged.
- Element value: e = {in_data[31]^in_neg, in_data[30:0]}. Zero-magnitude values are forced to +0 before use.
- Sources each cycle: R (ret_v) and E (in_valid & in_ready).
  - R and E both: issue (R, E); pend unchanged.
  - Exactly one source X, pend_v=1: issue (pend, X); pend_v<=0.
  - Exactly one source X, pend_v=0: pend<=X; pend_v<=1.
  - Neither: no action.
  - At most one issue per cycle, so no stall is required.
- States:
  - ACCUM: in_ready=1. On accepted in_last, go to DRAIN.
  - DRAIN: in_ready=0; combine rules apply with R only. When pend_v=1, inflight=0 and ret_v=0, go to OUT with sum_data<=pend, pend_v<=0.
  - OUT: sum_valid=1, in_ready=0. On sum_ready=1, sum_valid<=0 and go to ACCUM.
- Single-element row: pend holds the element with inflight=0. The sum appears 2 cycles after acceptance and no adder issue occurs.
- Empty rows cannot be expressed; in_last always accompanies a real element.
- Latency: for N>1 elements, the sum is available within roughly ceil(log2 N)*(LAT+1)+N+2 cycles after the first element.
- Summation order is not sequential. Results are bit-exact only against a reference that models this pairing order.
- Reset mid-row or mid-OUT abandons the row. Next behaviour is as after a fresh reset.

Decomposition:
- Shared package (jacobi_pkg):
  - FP_W=32, SIGN_BIT=31, FP_POS_ZERO=32'h0.
  - State encodings ACCUM/DRAIN/OUT.
- One natural sub-module: issue_tracker. It holds the LAT-deep valid shift register plus inflight counter, with ports issue, ret_v, inflight, rst, clk.

Test Plan:
- Elements 1.0, 2.0, 3.0, 4.0 (0x3F800000, 0x40000000, 0x40400000, 0x40800000), last on 4.0, with a behavioural adder of latency 6 → single sum_valid with sum_data=0x41200000 (10.0); inflight returns to 0.
- Single element 0x40A00000 with in_last → sum_data=0x40A00000 exactly 2 cycles later; add ce activity shows no issued pair.
- in_neg=1 on 2.0 within row {3.0, 2.0} → sum_data=0x3F800000 (1.0). Input 0x80000000 (-0) alone → sum_data=0x00000000.
- 17-element row of 1.0 with in_valid gaps every third cycle → sum_data=0x41880000 (17.0). Check in_ready=0 from in_last until the sum handshake completes.
- Hold sum_ready=0 for 10 cycles → sum_valid and sum_data stable, in_ready=0. Then assert sum_ready → next row accepted the cycle after.
- Assert rst=0 for 1 cycle mid-DRAIN with 3 results in flight → sum_valid stays 0. A following row {1.0, 1.0} yields 0x40000000 uncorrupted by stale returns.
